// File: rtl/soc_bram_ctl_if.sv
// Request/response bundle between an SoC bus master and soc_bram_ctl.
// Latency: none, wires only.
// Backpressure: none; the master holds valid and the controller answers with a one-cycle done pulse.
// Signals: addr (byte address), rw (1 = write), dwrite/dread (32-bit data), valid (request), done (completion).
interface soc_bram_ctl_if #(
  parameter int addr_width = 8
);
  logic [addr_width-1:0] addr;
  logic                  rw;
  logic [31:0]           dwrite;
  logic [31:0]           dread;
  logic                  valid;
  logic                  done;

  modport master (
    output addr, rw, dwrite, valid,
    input  dread, done
  );

  modport slave (
    input  addr, rw, dwrite, valid,
    output dread, done
  );
endinterface

// File: rtl/soc_bram_ctl.sv
// Byte-addressed 32-bit little-endian BRAM controller built from four byte-wide banks.
// Latency: accept in IDLE, banks accessed in ACCESS, done pulses in DONE; one request every 3 cycles.
// Backpressure: requests are only sampled in IDLE, so valid is simply held until the controller returns there.
// Ports: clk, rstn (async active-low), bus (slave modport: addr, rw, dwrite, valid in; dread, done out).
module soc_bram_ctl #(
  parameter int addr_width = 8
) (
  input logic            clk,
  input logic            rstn,
  soc_bram_ctl_if.slave  bus
);

  localparam int row_w = addr_width - 2;
  localparam int depth = 1 << row_w;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_nxt;
  logic   accept;
  logic   access;

  // Latched request; later bus changes cannot disturb an access in flight.
  logic [addr_width-1:0] addr_q;
  logic                  rw_q;
  logic [31:0]           wdat_q;

  logic [7:0]       bank_mem [4][depth];
  logic [row_w-1:0] bank_row [4];
  logic [7:0]       bank_wdat [4];

  // Bank output registers plus the offset used to rotate them into dread.
  // Only reads update them, so dread keeps the last read result across writes.
  logic [7:0] rd_q [4];
  logic [1:0] rd_off_q;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and strobes.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    access    = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        access    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      rw_q   <= 1'b0;
      wdat_q <= '0;
    end else if (accept) begin
      addr_q <= bus.addr;
      rw_q   <= bus.rw;
      wdat_q <= bus.dwrite;
    end
  end

  // Banks below the start offset hold the bytes that spill into the next row.
  // Row addition wraps naturally at the top of memory.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [1:0] sel;
      sel          = 2'(i) - addr_q[1:0];
      bank_row[i]  = addr_q[addr_width-1:2] + {{(row_w-1){1'b0}}, (2'(i) < addr_q[1:0])};
      bank_wdat[i] = wdat_q[{sel, 3'b000} +: 8];
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (access && rw_q) begin
      for (int i = 0; i < 4; i++) begin
        bank_mem[i][bank_row[i]] <= bank_wdat[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        rd_q[i] <= '0;
      end
      rd_off_q <= '0;
    end else if (access && !rw_q) begin
      for (int i = 0; i < 4; i++) begin
        rd_q[i] <= bank_mem[i][bank_row[i]];
      end
      rd_off_q <= addr_q[1:0];
    end
  end

  // dread byte k is taken from bank (offset + k) mod 4.
  always_comb begin
    bus.dread = '0;
    for (int k = 0; k < 4; k++) begin
      bus.dread[8*k +: 8] = rd_q[2'(rd_off_q + 2'(k))];
    end
  end

endmodule

// File: tb/tb_soc_bram_ctl.sv
// Self-checking bench for soc_bram_ctl: directed scenarios followed by random traffic.
// Latency: expects done in the third cycle of each transaction, one transaction per 3 cycles.
// Backpressure: exercises valid held high, valid low, and input changes after acceptance.
module tb_soc_bram_ctl;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  // Reference model: flat byte memory plus the last read word.
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_last;

  soc_bram_ctl_if #(.addr_width(8)) bus ();

  soc_bram_ctl #(.addr_width(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [7:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8] = ref_mem[8'(a + 8'(k))];
    end
    return w;
  endfunction

  function automatic void ref_write(input logic [7:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      ref_mem[8'(a + 8'(k))] = d[8*k +: 8];
    end
  endfunction

  // One full transaction starting from IDLE, called #1 after a rising edge.
  task automatic xact(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input bit scramble, output logic [31:0] got);
    logic [31:0] exp;
    bus.valid  = 1'b1;
    bus.rw     = w;
    bus.addr   = a;
    bus.dwrite = d;
    @(posedge clk); #1;
    check("done_early", {31'd0, bus.done}, 32'd0);
    bus.valid = 1'b0;
    if (scramble) begin
      bus.addr   = 8'($urandom);
      bus.dwrite = $urandom;
      bus.rw     = 1'($urandom);
    end
    @(posedge clk); #1;
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    exp = w ? ref_last : ref_read(a);
    check("dread", bus.dread, exp);
    got = bus.dread;
    if (w) ref_write(a, d);
    else   ref_last = exp;
    @(posedge clk); #1;
    check("done_width", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_last   = 32'h0;
    bus.valid  = 1'b0;
    bus.rw     = 1'b0;
    bus.addr   = '0;
    bus.dwrite = '0;
    rstn       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dread", bus.dread, 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Give every byte a known value so the model never sees unknowns.
    for (int r = 0; r < 64; r++) xact(1'b1, 8'(r * 4), 32'h0, 1'b0, got);

    // Aligned writes and reads.
    xact(1'b1, 8'd32, 32'h11223344, 1'b0, got);
    xact(1'b1, 8'd36, 32'h55667788, 1'b0, got);
    xact(1'b0, 8'd36, 32'h0, 1'b0, got);
    check("rd36", got, 32'h55667788);
    xact(1'b0, 8'd32, 32'h0, 1'b0, got);
    check("rd32", got, 32'h11223344);

    // Unaligned reads.
    xact(1'b0, 8'd34, 32'h0, 1'b0, got);
    check("rd34", got, 32'h77881122);
    xact(1'b0, 8'd33, 32'h0, 1'b0, got);
    check("rd33", got, 32'h88112233);

    // Unaligned write; dread must still hold the previous read.
    xact(1'b1, 8'd35, 32'hAABBCCDD, 1'b0, got);
    check("wr_keeps_dread", got, 32'h88112233);
    xact(1'b0, 8'd32, 32'h0, 1'b0, got);
    check("rd32_after_unal", got, 32'hDD223344);
    xact(1'b0, 8'd36, 32'h0, 1'b0, got);
    check("rd36_after_unal", got, 32'h55AABBCC);

    // Wrap-around at the top of memory.
    xact(1'b1, 8'd254, 32'hCAFEBABE, 1'b0, got);
    xact(1'b0, 8'd254, 32'h0, 1'b0, got);
    check("rd254", got, 32'hCAFEBABE);
    xact(1'b0, 8'd0, 32'h0, 1'b0, got);
    check("rd0_low", {16'h0, got[15:0]}, 32'h0000CAFE);

    // Inputs changed right after acceptance must not matter.
    xact(1'b1, 8'd64, 32'h0BADF00D, 1'b1, got);
    xact(1'b0, 8'd64, 32'h0, 1'b1, got);
    check("scramble_rd", got, 32'h0BADF00D);

    // valid held high: done every third cycle, one cycle wide.
    bus.valid = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 8'd32;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check("stream_done", {31'd0, bus.done}, (k % 3 == 2) ? 32'd1 : 32'd0);
    end
    bus.valid = 1'b0;
    ref_last  = ref_read(8'd32);
    check("stream_dread", bus.dread, ref_last);

    // valid low: no completion and no memory change.
    bus.rw     = 1'b1;
    bus.addr   = 8'd40;
    bus.dwrite = 32'hFFFFFFFF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("idle_done", {31'd0, bus.done}, 32'd0);
    end
    xact(1'b0, 8'd40, 32'h0, 1'b0, got);
    check("idle_nowrite", got, 32'h0);

    // Reset while a read is in ACCESS.
    bus.valid = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 8'd36;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_dread", bus.dread, 32'h0);
    ref_last = 32'h0;
    @(posedge clk); #1;
    check("rst_hold_done", {31'd0, bus.done}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset while a write is in ACCESS: the write must be dropped.
    bus.valid  = 1'b1;
    bus.rw     = 1'b1;
    bus.addr   = 8'd100;
    bus.dwrite = 32'h12345678;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 8'd100, 32'h0, 1'b0, got);
    check("rst_drop_write", got, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      xact(1'($urandom), 8'($urandom), $urandom, 1'($urandom), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
